fetch_unit: RTL and testbench

//   Instruction fetch stage. Holds the PC and issues one word request at a time to instruction memory.

---
 rtl/fetch_unit.sv | 139 +++++++++++++
 tb/tb_fetch_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module     : fetch_unit
// Description: Instruction fetch stage. Holds the PC, issues at most one
//              outstanding word request to instruction memory, and hands
//              the returned instruction plus its PC to decode over a
//              valid/ready handshake. PC redirects are accepted in every
//              state; a response belonging to a squashed request is dropped.
// Ports      : clk, rst              - clock, synchronous active-high reset
//              imem_req_*            - request channel (valid/ready/addr)
//              imem_resp_*           - response channel (valid/data)
//              instr_*               - decode channel (valid/ready/out/pc)
//              redirect_valid/_pc    - branch/jump target
//              fetch_err             - one-cycle pulse on misaligned redirect
// Revision   : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr_out,
    output logic [XLEN-1:0] instr_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fetch_err
);

    localparam logic [1:0] S_REQ  = 2'd0;  // request may be issued
    localparam logic [1:0] S_WAIT = 2'd1;  // request accepted, awaiting word
    localparam logic [1:0] S_HOLD = 2'd2;  // instruction presented to decode
    localparam logic [1:0] S_DROP = 2'd3;  // awaiting a squashed response

    localparam logic [XLEN-1:0] C_PC_STEP = XLEN'(4);

    logic [1:0]      state_q,       state_d;
    logic [XLEN-1:0] pc_q,          pc_d;
    logic [31:0]     instr_out_q,   instr_out_d;
    logic [XLEN-1:0] instr_pc_q,    instr_pc_d;
    logic            instr_valid_q, instr_valid_d;
    logic            fetch_err_q,   fetch_err_d;

    logic            w_req_fire;
    logic [XLEN-1:0] w_redirect_aligned;

    assign w_req_fire         = (state_q == S_REQ) && imem_req_ready;
    assign w_redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_out_d   = instr_out_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        fetch_err_d   = 1'b0;

        if (redirect_valid) begin
            // Redirect outranks every normal transition. Any request already
            // in memory must have its response swallowed in S_DROP so that a
            // stale word can never reach decode.
            pc_d          = w_redirect_aligned;
            fetch_err_d   = (redirect_pc[1:0] != 2'b00);
            instr_valid_d = 1'b0;
            case (state_q)
                S_REQ:   state_d = w_req_fire      ? S_DROP : S_REQ;
                S_WAIT:  state_d = imem_resp_valid ? S_REQ  : S_DROP;
                S_HOLD:  state_d = S_REQ;
                S_DROP:  state_d = imem_resp_valid ? S_REQ  : S_DROP;
                default: state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (imem_req_ready) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        instr_out_d   = imem_resp_data;
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                        pc_d          = pc_q + C_PC_STEP;  // wraps modulo 2^XLEN
                        state_d       = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (instr_ready) begin
                        instr_valid_d = 1'b0;
                        state_d       = S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_resp_valid) begin
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            instr_out_q   <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_out_q   <= instr_out_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            fetch_err_q   <= fetch_err_d;
        end
    end

    // Request is suppressed combinationally during reset so nothing is
    // issued before the state register has been initialised.
    assign imem_req_valid = !rst && (state_q == S_REQ);
    assign imem_req_addr  = pc_q;
    assign instr_valid    = instr_valid_q;
    assign instr_out      = instr_out_q;
    assign instr_pc       = instr_pc_q;
    assign fetch_err      = fetch_err_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module     : tb_fetch_unit
// Description: Directed self-checking bench for fetch_unit. Instance A uses
//              RESET_PC=0; instance B uses RESET_PC=0xFFFFFFFC to cover PC
//              wrap-around and reset while a request is outstanding.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Instance A signals
    logic        rst, req_valid, req_ready, resp_valid, i_valid, i_ready;
    logic        redir_valid, f_err;
    logic [31:0] req_addr, resp_data, i_out, i_pc, redir_pc;

    // Instance B signals
    logic        rst2, req_valid2, req_ready2, resp_valid2, i_valid2, i_ready2;
    logic        redir_valid2, f_err2;
    logic [31:0] req_addr2, resp_data2, i_out2, i_pc2, redir_pc2;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) u_dut_a (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
        .imem_resp_valid(resp_valid), .imem_resp_data(resp_data),
        .instr_valid(i_valid), .instr_ready(i_ready), .instr_out(i_out), .instr_pc(i_pc),
        .redirect_valid(redir_valid), .redirect_pc(redir_pc), .fetch_err(f_err)
    );

    fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) u_dut_b (
        .clk(clk), .rst(rst2),
        .imem_req_valid(req_valid2), .imem_req_ready(req_ready2), .imem_req_addr(req_addr2),
        .imem_resp_valid(resp_valid2), .imem_resp_data(resp_data2),
        .instr_valid(i_valid2), .instr_ready(i_ready2), .instr_out(i_out2), .instr_pc(i_pc2),
        .redirect_valid(redir_valid2), .redirect_pc(redir_pc2), .fetch_err(f_err2)
    );

    // Instruction word memory returns for a given address
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[23:0], 8'h13};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs set afterwards are sampled at the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full fetch on instance A with 1-cycle accept and 1-cycle response.
    task automatic fetch_one(input logic [31:0] addr, input string tag);
        check({tag, " req_valid"}, {31'd0, req_valid}, 32'd1);
        check({tag, " req_addr"}, req_addr, addr);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        check({tag, " wait req_valid"}, {31'd0, req_valid}, 32'd0);
        resp_valid = 1'b1;
        resp_data  = word_at(addr);
        tick();
        resp_valid = 1'b0;
        check({tag, " instr_valid"}, {31'd0, i_valid}, 32'd1);
        check({tag, " instr_out"}, i_out, word_at(addr));
        check({tag, " instr_pc"}, i_pc, addr);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        check({tag, " consumed"}, {31'd0, i_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; req_ready = 0; resp_valid = 0; resp_data = 0; i_ready = 0;
        redir_valid = 0; redir_pc = 0;
        rst2 = 1'b1; req_ready2 = 0; resp_valid2 = 0; resp_data2 = 0; i_ready2 = 0;
        redir_valid2 = 0; redir_pc2 = 0;
        tick();
        tick();

        // Reset state
        check("rst req_valid", {31'd0, req_valid}, 32'd0);
        check("rst instr_valid", {31'd0, i_valid}, 32'd0);
        check("rst instr_out", i_out, 32'd0);
        check("rst instr_pc", i_pc, 32'd0);
        check("rst fetch_err", {31'd0, f_err}, 32'd0);
        rst = 1'b0;
        #1;

        // 1. Sequential fetch, 3 cycles per instruction
        fetch_one(32'h0, "seq0");
        fetch_one(32'h4, "seq4");
        fetch_one(32'h8, "seq8");

        // 2. Back-pressure in S_HOLD
        check("bp req_addr", req_addr, 32'hC);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        resp_valid = 1'b1;
        resp_data  = word_at(32'hC);
        tick();
        resp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp instr_valid", {31'd0, i_valid}, 32'd1);
            check("bp instr_out", i_out, word_at(32'hC));
            check("bp instr_pc", i_pc, 32'hC);
            check("bp req_valid", {31'd0, req_valid}, 32'd0);
            // a spurious response must be ignored while holding
            resp_valid = (i == 2);
            resp_data  = 32'hDEAD_BEEF;
            tick();
        end
        resp_valid = 1'b0;
        check("bp still held", i_out, word_at(32'hC));
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        check("bp released", {31'd0, i_valid}, 32'd0);

        // 3. Redirect in S_WAIT before the response arrives
        check("r3 req_addr", req_addr, 32'h10);
        req_ready = 1'b1;
        tick();
        req_ready   = 1'b0;
        redir_valid = 1'b1;
        redir_pc    = 32'h100;
        tick();
        redir_valid = 1'b0;
        check("r3 drop req_valid", {31'd0, req_valid}, 32'd0);
        check("r3 no fetch_err", {31'd0, f_err}, 32'd0);
        resp_valid = 1'b1;
        resp_data  = word_at(32'h10);
        tick();
        resp_valid = 1'b0;
        check("r3 stale discarded", {31'd0, i_valid}, 32'd0);
        fetch_one(32'h100, "r3 new");

        // 4. Redirect coincident with request accept at 0x8
        redir_valid = 1'b1;
        redir_pc    = 32'h8;
        tick();
        check("r4 stay req", {31'd0, req_valid}, 32'd1);
        check("r4 addr 8", req_addr, 32'h8);
        redir_pc  = 32'h200;
        req_ready = 1'b1;
        tick();
        redir_valid = 1'b0;
        req_ready   = 1'b0;
        check("r4 drop req_valid", {31'd0, req_valid}, 32'd0);
        resp_valid = 1'b1;
        resp_data  = word_at(32'h8);
        tick();
        resp_valid = 1'b0;
        check("r4 stale discarded", {31'd0, i_valid}, 32'd0);
        fetch_one(32'h200, "r4 new");

        // 5. Misaligned redirect pulses fetch_err for one cycle
        redir_valid = 1'b1;
        redir_pc    = 32'h102;
        tick();
        redir_valid = 1'b0;
        check("r5 fetch_err", {31'd0, f_err}, 32'd1);
        check("r5 aligned addr", req_addr, 32'h100);
        tick();
        check("r5 err pulse end", {31'd0, f_err}, 32'd0);

        // Redirect while holding without instr_ready squashes the instruction
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        resp_valid = 1'b1;
        resp_data  = word_at(32'h100);
        tick();
        resp_valid = 1'b0;
        check("hold sq valid", {31'd0, i_valid}, 32'd1);
        redir_valid = 1'b1;
        redir_pc    = 32'h300;
        tick();
        redir_valid = 1'b0;
        check("hold sq squashed", {31'd0, i_valid}, 32'd0);
        check("hold sq addr", req_addr, 32'h300);

        // 6. RESET_PC=0xFFFFFFFC: wrap, then reset while waiting
        rst2 = 1'b0;
        #1;
        check("b req_addr", req_addr2, 32'hFFFF_FFFC);
        req_ready2 = 1'b1;
        tick();
        req_ready2  = 1'b0;
        resp_valid2 = 1'b1;
        resp_data2  = 32'h1234_5678;
        tick();
        resp_valid2 = 1'b0;
        check("b instr_out", i_out2, 32'h1234_5678);
        check("b instr_pc", i_pc2, 32'hFFFF_FFFC);
        i_ready2 = 1'b1;
        tick();
        i_ready2 = 1'b0;
        check("b wrap addr", req_addr2, 32'h0);
        req_ready2 = 1'b1;
        tick();
        req_ready2 = 1'b0;
        check("b waiting", {31'd0, req_valid2}, 32'd0);
        rst2 = 1'b1;
        tick();
        rst2 = 1'b0;
        #1;
        check("b rst instr_valid", {31'd0, i_valid2}, 32'd0);
        check("b rst req_valid", {31'd0, req_valid2}, 32'd1);
        check("b rst addr", req_addr2, 32'hFFFF_FFFC);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
